platform_indexer: RTL and testbench

- Parametrised successor to the single-turn colour platform driver for the M&M sorter.
- Drives the unipolar stepper that turns the bin platform. It keeps track of absolute position and moves to any of NUM_BINS bin positions by the shortest path.
- Supports full-step or half-step drive.
- On arrival it handshakes with the latch motor controller, then returns to idle to accept the next sort request.

---
 rtl/platform_indexer.sv | 179 +++++++++++++++++
 tb/tb_platform_indexer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/platform_indexer.sv
// Bin-platform stepper indexer for the M&M sorter: tracks absolute position, moves to the
// requested bin by the shortest path, then handshakes with the latch motor controller.
module platform_indexer #(
    parameter int NUM_BINS      = 8,
    parameter int STEPS_PER_REV = 2048,
    parameter int STEPS_PER_BIN = 256,
    parameter int STEP_CLKS     = 100_000,
    parameter int HALF_STEP     = 0,
    parameter int LATCH_TIMEOUT = 50_000_000,
    parameter int POS_W         = $clog2(STEPS_PER_REV)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_BINS-1:0] colour,
    input  logic                home_req,
    input  logic                latch_done,
    output logic [3:0]          coil,
    output logic                latch_req,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [POS_W-1:0]    position
);

    localparam int ST_W = (STEP_CLKS > 2) ? $clog2(STEP_CLKS) : 1;
    localparam int WT_W = $clog2(LATCH_TIMEOUT + 1);
    localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(STEP_CLKS - 1);
    localparam logic [WT_W-1:0]  WAIT_LAST = WT_W'(LATCH_TIMEOUT - 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(STEPS_PER_REV - 1);

    typedef enum logic [1:0] {IDLE, MOVE, LATCH} state_t;

    state_t           state;
    logic [2:0]       phase_idx;
    logic [ST_W-1:0]  step_timer;
    logic [POS_W-1:0] steps_left;
    logic [WT_W-1:0]  wait_cnt;
    logic             dir_cw;

    int               bin_idx;
    int               delta;
    logic             colour_valid;
    logic             go_cw;
    logic [POS_W-1:0] move_steps;
    logic [2:0]       adv_phase;

    // Wave drive only uses the low two index bits, so clearing bit 2 wraps modulo 4.
    function automatic logic [2:0] next_phase(input logic [2:0] idx, input logic cw);
        logic [2:0] n;
        n = cw ? idx + 3'd1 : idx - 3'd1;
        if (HALF_STEP == 0) n[2] = 1'b0;
        return n;
    endfunction

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        logic [3:0] p;
        p = 4'b0000;
        if (HALF_STEP != 0) begin
            case (idx)
                3'd0: p = 4'b1000;
                3'd1: p = 4'b1100;
                3'd2: p = 4'b0100;
                3'd3: p = 4'b0110;
                3'd4: p = 4'b0010;
                3'd5: p = 4'b0011;
                3'd6: p = 4'b0001;
                default: p = 4'b1001;
            endcase
        end else begin
            case (idx[1:0])
                2'd0: p = 4'b1000;
                2'd1: p = 4'b0100;
                2'd2: p = 4'b0010;
                default: p = 4'b0001;
            endcase
        end
        return p;
    endfunction

    always_comb begin
        bin_idx = 0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (colour[i]) bin_idx = i;
        end
        colour_valid = (colour != '0) && ((colour & (colour - NUM_BINS'(1))) == '0);
        delta = bin_idx * STEPS_PER_BIN - int'(position);
        if (delta < 0) delta = delta + STEPS_PER_REV;
        go_cw      = (delta <= STEPS_PER_REV / 2);
        move_steps = go_cw ? POS_W'(delta) : POS_W'(STEPS_PER_REV - delta);
        adv_phase  = next_phase(phase_idx, (state == IDLE) ? go_cw : dir_cw);
    end

    // Coil is loaded on the transition edge so the new pattern appears on the first MOVE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            coil       <= 4'b0000;
            latch_req  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            position   <= '0;
            phase_idx  <= 3'd0;
            step_timer <= '0;
            steps_left <= '0;
            wait_cnt   <= '0;
            dir_cw     <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    coil      <= 4'b0000;
                    latch_req <= 1'b0;
                    busy      <= 1'b0;
                    if (home_req) begin
                        position <= '0;
                    end else if (start) begin
                        if (!colour_valid) begin
                            err <= 1'b1;
                        end else if (delta == 0) begin
                            state     <= LATCH;
                            latch_req <= 1'b1;
                            busy      <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            state      <= MOVE;
                            busy       <= 1'b1;
                            dir_cw     <= go_cw;
                            steps_left <= move_steps;
                            step_timer <= '0;
                            phase_idx  <= adv_phase;
                            coil       <= phase_pattern(adv_phase);
                        end
                    end
                end
                MOVE: begin
                    if (step_timer == STEP_LAST) begin
                        step_timer <= '0;
                        steps_left <= steps_left - POS_W'(1);
                        if (dir_cw)
                            position <= (position == POS_MAX) ? '0 : position + POS_W'(1);
                        else
                            position <= (position == '0) ? POS_MAX : position - POS_W'(1);
                        if (steps_left == POS_W'(1)) begin
                            coil      <= 4'b0000;
                            state     <= LATCH;
                            latch_req <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            phase_idx <= adv_phase;
                            coil      <= phase_pattern(adv_phase);
                        end
                    end else begin
                        step_timer <= step_timer + ST_W'(1);
                    end
                end
                LATCH: begin
                    if (latch_done) begin
                        latch_req <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        latch_req <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_indexer.sv
// Directed bench for platform_indexer: wave-drive instance for most scenarios,
// a second half-step instance for the half-step phase sequence.
module tb_platform_indexer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, home_req = 1'b0, latch_done = 1'b0;
    logic [7:0] colour = 8'h00;
    logic [3:0] coil;
    logic       latch_req, busy, done, err;
    logic [3:0] position;

    logic       start_h = 1'b0, latch_done_h = 1'b0;
    logic [7:0] colour_h = 8'h00;
    logic [3:0] coil_h;
    logic       latch_req_h, busy_h, done_h, err_h;
    logic [3:0] position_h;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    platform_indexer #(.NUM_BINS(8), .STEPS_PER_REV(16), .STEPS_PER_BIN(2), .STEP_CLKS(4),
                       .HALF_STEP(0), .LATCH_TIMEOUT(20)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .colour(colour), .home_req(home_req),
        .latch_done(latch_done), .coil(coil), .latch_req(latch_req), .busy(busy),
        .done(done), .err(err), .position(position));

    platform_indexer #(.NUM_BINS(8), .STEPS_PER_REV(16), .STEPS_PER_BIN(2), .STEP_CLKS(4),
                       .HALF_STEP(1), .LATCH_TIMEOUT(20)) dut_h (
        .clk(clk), .reset_n(reset_n), .start(start_h), .colour(colour_h), .home_req(1'b0),
        .latch_done(latch_done_h), .coil(coil_h), .latch_req(latch_req_h), .busy(busy_h),
        .done(done_h), .err(err_h), .position(position_h));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on the first MOVE cycle; coils holds one nibble per step, step 0 in the low nibble.
    task automatic run_move(input logic [31:0] coils, input int n, input int pos0, input bit cw);
        int exp_pos;
        for (int s = 0; s < n; s++) begin
            exp_pos = cw ? (pos0 + s) % 16 : (pos0 - s + 32) % 16;
            check_output($sformatf("coil_step%0d_first", s), 32'(coil), 32'(coils[4*s +: 4]));
            check_output($sformatf("pos_step%0d", s), 32'(position), 32'(exp_pos));
            check_output($sformatf("busy_step%0d", s), 32'(busy), 32'd1);
            step(3);
            check_output($sformatf("coil_step%0d_last", s), 32'(coil), 32'(coils[4*s +: 4]));
            step(1);
        end
        exp_pos = cw ? (pos0 + n) % 16 : (pos0 - n + 32) % 16;
        check_output("coil_after_move", 32'(coil), 32'h0);
        check_output("latch_req_after_move", 32'(latch_req), 32'd1);
        check_output("pos_after_move", 32'(position), 32'(exp_pos));
    endtask

    task automatic apply_latch_done();
        latch_done = 1'b1;
        step(1);
        latch_done = 1'b0;
        check_output("done_pulse", 32'(done), 32'd1);
        check_output("latch_req_released", 32'(latch_req), 32'd0);
        check_output("busy_cleared", 32'(busy), 32'd0);
        check_output("err_with_done", 32'(err), 32'd0);
        step(1);
        check_output("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        step(2);
        check_output("reset_coil", 32'(coil), 32'h0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_pos", 32'(position), 32'd0);
        check_output("reset_latch_req", 32'(latch_req), 32'd0);
        check_output("reset_done_err", 32'({done, err}), 32'd0);
        reset_n = 1'b1;
        step(1);

        // Bin 2: CW four steps
        start = 1'b1; colour = 8'b0000_0100;
        step(1);
        start = 1'b0;
        run_move(32'h0000_8124, 4, 0, 1'b1);
        apply_latch_done();

        // Bin 7 from 4: CCW six steps through 0
        start = 1'b1; colour = 8'b1000_0000;
        step(1);
        start = 1'b0;
        run_move(32'h0021_8421, 6, 4, 1'b0);
        apply_latch_done();

        // Home, then bin 4: half-revolution tie goes CW
        home_req = 1'b1;
        step(1);
        home_req = 1'b0;
        check_output("home_pos", 32'(position), 32'd0);
        start = 1'b1; colour = 8'b0001_0000;
        step(1);
        start = 1'b0;
        run_move(32'h2481_2481, 8, 0, 1'b1);
        apply_latch_done();

        // Half-step instance: bin 1 from 0
        start_h = 1'b1; colour_h = 8'b0000_0010;
        step(1);
        start_h = 1'b0;
        check_output("half_coil0_first", 32'(coil_h), 32'b1100);
        step(3);
        check_output("half_coil0_last", 32'(coil_h), 32'b1100);
        step(1);
        check_output("half_coil1_first", 32'(coil_h), 32'b0100);
        check_output("half_pos1", 32'(position_h), 32'd1);
        step(3);
        check_output("half_coil1_last", 32'(coil_h), 32'b0100);
        step(1);
        check_output("half_coil_off", 32'(coil_h), 32'h0);
        check_output("half_latch_req", 32'(latch_req_h), 32'd1);
        check_output("half_pos2", 32'(position_h), 32'd2);
        latch_done_h = 1'b1;
        step(1);
        latch_done_h = 1'b0;
        check_output("half_done", 32'(done_h), 32'd1);

        // Invalid colours at position 8
        start = 1'b1; colour = 8'b0000_0000;
        step(1);
        start = 1'b0;
        check_output("err_zero_colour", 32'(err), 32'd1);
        check_output("err_zero_state", 32'({busy, coil, position}), 32'({1'b0, 4'b0000, 4'd8}));
        step(1);
        check_output("err_zero_one_cycle", 32'(err), 32'd0);
        start = 1'b1; colour = 8'b0000_0011;
        step(1);
        start = 1'b0;
        check_output("err_multi_colour", 32'(err), 32'd1);
        check_output("err_multi_state", 32'({busy, coil, position}), 32'({1'b0, 4'b0000, 4'd8}));
        step(1);

        // Bin 3 from 8: CCW two steps to position 6
        start = 1'b1; colour = 8'b0000_1000;
        step(1);
        start = 1'b0;
        run_move(32'h0000_0084, 2, 8, 1'b0);
        apply_latch_done();

        // home_req wins over a simultaneous start
        home_req = 1'b1; start = 1'b1; colour = 8'b0000_0001;
        step(1);
        home_req = 1'b0; start = 1'b0;
        check_output("home_prio_pos", 32'(position), 32'd0);
        check_output("home_prio_busy", 32'(busy), 32'd0);
        step(1);
        check_output("home_prio_no_move", 32'({busy, coil, err}), 32'd0);

        // Bin 1 with start held through MOVE, then latch timeout
        start = 1'b1; colour = 8'b0000_0010;
        step(1);
        colour = 8'b1000_0000;
        run_move(32'h0000_0024, 2, 0, 1'b1);
        start = 1'b0;
        step(19);
        check_output("timeout_wait_req", 32'(latch_req), 32'd1);
        check_output("timeout_wait_err", 32'(err), 32'd0);
        step(1);
        check_output("timeout_err", 32'(err), 32'd1);
        check_output("timeout_req_drop", 32'(latch_req), 32'd0);
        check_output("timeout_busy", 32'(busy), 32'd0);
        check_output("timeout_no_done", 32'(done), 32'd0);
        check_output("timeout_pos_kept", 32'(position), 32'd2);
        step(1);
        check_output("timeout_err_one_cycle", 32'(err), 32'd0);

        // Bin 7 from 2: CCW, reset during the first step
        start = 1'b1; colour = 8'b1000_0000;
        step(1);
        start = 1'b0;
        check_output("pre_reset_coil", 32'(coil), 32'b0100);
        step(2);
        reset_n = 1'b0;
        #2;
        check_output("async_reset_coil", 32'(coil), 32'h0);
        check_output("async_reset_busy", 32'(busy), 32'd0);
        check_output("async_reset_pos", 32'(position), 32'd0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // Bin 1 after reset: CW two steps from phase 0
        start = 1'b1; colour = 8'b0000_0010;
        step(1);
        start = 1'b0;
        run_move(32'h0000_0024, 2, 0, 1'b1);
        apply_latch_done();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
